// File: rtl/vector_requester_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vector_requester_pkg : shared types, default widths and expected-value      |
// |                        helpers for the vector requester                     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package vector_requester_pkg;

    localparam int c_data_w = 128;
    localparam int c_cnt_w  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [c_data_w-1:0] exp_meth(input logic [c_data_w-1:0] base,
                                                      input logic [c_data_w-1:0] idx);
        return base + idx;
    endfunction

    function automatic logic [c_data_w-1:0] exp_v(input logic [c_data_w-1:0] base,
                                                   input logic [c_data_w-1:0] idx);
        return base ^ idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vector_requester_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vector_requester_if : start / say / heard handshakes and status signals     |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
interface vector_requester_if
    import vector_requester_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int CNT_W  = c_cnt_w
);

    logic              start__ENA;
    logic [CNT_W-1:0]  start_count;
    logic [DATA_W-1:0] start_base;
    logic              start__RDY;

    logic              say__ENA;
    logic [DATA_W-1:0] say_meth;
    logic [DATA_W-1:0] say_v;
    logic              say__RDY;

    logic              heard__ENA;
    logic [DATA_W-1:0] heard_meth;
    logic [DATA_W-1:0] heard_v;
    logic              heard__RDY;

    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  rx_count;
    logic [CNT_W-1:0]  err_count;
    logic              timeout;

    // master: the requester itself; slave: whoever drives start and plays responder
    modport master (
        input  start__ENA, start_count, start_base, say__RDY, heard__ENA, heard_meth, heard_v,
        output start__RDY, say__ENA, say_meth, say_v, heard__RDY,
               busy, done, rx_count, err_count, timeout
    );

    modport slave (
        output start__ENA, start_count, start_base, say__RDY, heard__ENA, heard_meth, heard_v,
        input  start__RDY, say__ENA, say_meth, say_v, heard__RDY,
               busy, done, rx_count, err_count, timeout
    );

endinterface
`default_nettype wire

// File: rtl/vector_requester_credit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vector_requester_credit : up/down count of says awaiting heard              |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module vector_requester_credit #(
    parameter int MAX_OUT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    input  logic clear,
    output logic full,
    output logic empty
);

    localparam int c_cnt_w = 4;

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && !dec) begin
            r_count <= r_count + c_cnt_w'(1);
        end else if (dec && !inc) begin
            r_count <= r_count - c_cnt_w'(1);
        end
    end

    assign full  = (r_count == c_cnt_w'(MAX_OUT));
    assign empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/vector_requester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vector_requester : burst traffic source and in-order checker for a vector   |
// |                    responder; VECTOR_REQUESTER_TIMEOUT_EN adds a watchdog   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module vector_requester
    import vector_requester_pkg::*;
#(
    parameter int DATA_W      = c_data_w,
    parameter int CNT_W       = c_cnt_w,
    parameter int MAX_OUT     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               CLK,
    input  logic               nRST,
    vector_requester_if.master bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_base;
    logic [CNT_W-1:0]  r_tx_idx;
    logic [CNT_W-1:0]  r_rx_idx;
    logic [CNT_W-1:0]  r_rx_count;
    logic [CNT_W-1:0]  r_err_count;

    logic w_start_fire;
    logic w_say_fire;
    logic w_heard_valid;
    logic w_unsolicited;
    logic w_match;
    logic w_err_evt;
    logic w_last_say;
    logic w_full;
    logic w_empty;
    logic w_busy;
    logic w_to_hit;

    generate
        if (MAX_OUT < 1 || MAX_OUT > 15) begin : g_chk_max_out
            $error("vector_requester: MAX_OUT must be within 1..15");
        end
        if (TIMEOUT_CYC < 1) begin : g_chk_timeout
            $error("vector_requester: TIMEOUT_CYC must be positive");
        end
    endgenerate

    assign bus.start__RDY = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign bus.say__ENA   = (r_state == ST_RUN) && !w_full;
    assign bus.heard__RDY = 1'b1;
    assign w_busy         = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign bus.busy       = w_busy;
    assign bus.done       = (r_state == ST_DONE);
    assign bus.rx_count   = r_rx_count;
    assign bus.err_count  = r_err_count;

    assign bus.say_meth = DATA_W'(exp_meth(c_data_w'(r_base), c_data_w'(r_tx_idx)));
    assign bus.say_v    = DATA_W'(exp_v(c_data_w'(r_base), c_data_w'(r_tx_idx)));

    assign w_start_fire  = bus.start__ENA && bus.start__RDY;
    assign w_say_fire    = bus.say__ENA && bus.say__RDY;
    // heard__RDY is constant 1, so heard__ENA alone is a fire
    assign w_heard_valid = bus.heard__ENA && !w_empty;
    assign w_unsolicited = bus.heard__ENA && w_empty;
    assign w_match       = (bus.heard_meth == DATA_W'(exp_meth(c_data_w'(r_base), c_data_w'(r_rx_idx))))
                        && (bus.heard_v == DATA_W'(exp_v(c_data_w'(r_base), c_data_w'(r_rx_idx))));
    assign w_err_evt     = (w_heard_valid && !w_match) || w_unsolicited || w_to_hit;
    assign w_last_say    = ((r_tx_idx + CNT_W'(1)) == r_count);

    vector_requester_credit #(
        .MAX_OUT (MAX_OUT)
    ) u_credit (
        .clk   (CLK),
        .rst_n (nRST),
        .inc   (w_say_fire),
        .dec   (w_heard_valid),
        .clear (w_start_fire || w_to_hit),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_fire) begin
                    w_state_nxt = (bus.start_count == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_say_fire && w_last_say) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_empty) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_to_hit) begin
            w_state_nxt = ST_DONE;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_count     <= '0;
            r_base      <= '0;
            r_tx_idx    <= '0;
            r_rx_idx    <= '0;
            r_rx_count  <= '0;
            r_err_count <= '0;
        end else if (w_start_fire) begin
            r_count     <= bus.start_count;
            r_base      <= bus.start_base;
            r_tx_idx    <= '0;
            r_rx_idx    <= '0;
            r_rx_count  <= '0;
            r_err_count <= '0;
        end else begin
            if (w_say_fire) begin
                r_tx_idx <= r_tx_idx + CNT_W'(1);
            end
            if (w_heard_valid) begin
                r_rx_idx <= r_rx_idx + CNT_W'(1);
            end
            if (w_heard_valid && w_match && (r_rx_count != '1)) begin
                r_rx_count <= r_rx_count + CNT_W'(1);
            end
            if (w_err_evt && (r_err_count != '1)) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
        end
    end

`ifdef VECTOR_REQUESTER_TIMEOUT_EN
    localparam int c_stall_w = $clog2(TIMEOUT_CYC + 1);

    logic [c_stall_w-1:0] r_stall;
    logic                 r_timeout;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall <= '0;
        end else if (w_start_fire || bus.heard__ENA || w_to_hit) begin
            r_stall <= '0;
        end else if (w_busy && !w_empty) begin
            r_stall <= r_stall + c_stall_w'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_timeout <= 1'b0;
        end else if (w_start_fire) begin
            r_timeout <= 1'b0;
        end else if (w_to_hit) begin
            r_timeout <= 1'b1;
        end
    end

    // a heard arriving on the limit cycle rescues the burst
    assign w_to_hit    = w_busy && (r_stall == c_stall_w'(TIMEOUT_CYC)) && !bus.heard__ENA;
    assign bus.timeout = r_timeout;
`else
    assign w_to_hit    = 1'b0;
    assign bus.timeout = 1'b0;
`endif

endmodule
`default_nettype wire
